// File: rtl/nn_pkg.sv
// Shared neural-network types and helpers: activation width, MAC state encoding,
// and the ReLU/saturate clamp used on the neuron output path.
package nn_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ACCEPT,
    DRAIN,
    OUTPUT
  } state_e;

  // Clamp to [0, max_v]: negatives are rectified, large positives saturate.
  function automatic logic signed [63:0] relu_sat(input logic signed [63:0] v,
                                                  input logic signed [63:0] max_v);
    if (v < 0)          return '0;
    else if (v > max_v) return max_v;
    else                return v;
  endfunction

endpackage

// File: rtl/neuron_relu_sat.sv
// Combinational output stage: adds the neuron bias to the accumulator, rescales by
// FRAC_BITS, then rectifies and saturates to a non-negative DATA_WIDTH activation.
module neuron_relu_sat #(
  parameter int ACC_W      = 19,
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 0,
  parameter int BIAS       = 0
) (
  input  logic signed [ACC_W-1:0]      acc,
  output logic        [DATA_WIDTH-1:0] act
);
  import nn_pkg::*;

  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;

  logic signed [63:0] biased;
  logic signed [63:0] shifted;

  always_comb begin
    biased  = 64'(acc) + 64'(BIAS);
    shifted = biased >>> FRAC_BITS;
    act     = DATA_WIDTH'(relu_sat(shifted, SAT_MAX));
  end

endmodule

// File: rtl/neuron_mac.sv
// Per-neuron multiply-accumulate: streams NUM_WEIGHT activations against a
// registered-read weight memory, accumulates, and emits one ReLU'd 8-bit result.
module neuron_mac #(
  parameter int NUM_WEIGHT = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = nn_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = 0,
  parameter int BIAS       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] radd,
  input  logic [DATA_WIDTH-1:0] wout,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);
  import nn_pkg::*;

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(NUM_WEIGHT) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WEIGHT - 1);

  state_e                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] x_q, x_d;
  logic signed [PROD_W-1:0]     prod_q, prod_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [1:0]                   vld_pipe_q, vld_pipe_d;
  logic                         out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0]        act;
  logic                         accept;

  neuron_relu_sat #(
    .ACC_W     (ACC_W),
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .BIAS      (BIAS)
  ) u_relu_sat (
    .acc(acc_q),
    .act(act)
  );

  assign in_ready  = (state_q == ACCEPT) && !rst;
  assign accept    = in_valid && in_ready;
  assign ren       = accept;
  assign radd      = cnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    // bit 0: operand aligned with the memory read; bit 1: product ready to accumulate
    vld_pipe_d  = {vld_pipe_q[0], accept};
    x_d         = accept ? $signed(in_data) : x_q;
    prod_d      = vld_pipe_q[0] ? PROD_W'(x_q) * PROD_W'($signed(wout)) : prod_q;
    acc_d       = vld_pipe_q[1] ? acc_q + ACC_W'(prod_q) : acc_q;

    case (state_q)
      ACCEPT: begin
        if (accept) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (vld_pipe_q == 2'b00) state_d = OUTPUT;
      end
      OUTPUT: begin
        out_data_d  = act;
        out_valid_d = 1'b1;
        acc_d       = '0;
        state_d     = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCEPT;
      cnt_q       <= '0;
      x_q         <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      vld_pipe_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      vld_pipe_q  <= vld_pipe_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
